lfsr_rng_arbiter: RTL and testbench
===================================

Name: lfsr_rng_arbiter

Overview:
- Shared pseudo-random source for the project: one 16-bit Fibonacci LFSR (polynomial x^16+x^14+x^13+x^11) served to N_REQ requesters (game FSM, pattern generator, timers, ...).
- Handles seeding, warm-up stepping, round-robin arbitration and a four-phase req/ack handshake.
- Each grant delivers one fresh 16-bit word and advances the LFSR exactly once, so sequences are deterministic for a given seed and grant order.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WARMUP, 16, LFSR steps performed after reset or seed load before serving (0..255; 0 = serve immediately).
- DEFAULT_SEED, 16'hACE1, seed after reset and substitute for an all-zero seed.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- seed_load  in  1  one-cycle strobe: load seed and restart warm-up.
- seed  in  16  seed value, sampled when seed_load=1.
- req  in  N_REQ  per-requester request, level, held until ack seen.
- ack  out  N_REQ  one-hot grant/acknowledge, registered.
- value  out  16  random word for the current grant, registered, stable while ack is high.
- ready  out  1  high in state RUN (idle, able to grant).
- busy  out  1  high in state WARM.

Behaviour:
- LFSR step: fb = s[15]^s[13]^s[12]^s[10]; next = {s[14:0], fb}. Steps only in WARM and on a grant edge; never free-runs.
- Reset (async): lfsr=DEFAULT_SEED, warm counter=WARMUP, ptr=0, ack=0, value=16'h0000. State is WARM, or RUN if WARMUP=0. ready/busy follow the state.
- States: WARM, RUN, GRANT.
- WARM:
  - Each clock: lfsr steps and counter decrements.
  - On the edge where counter goes 1->0: state=RUN.
  - req is ignored; ack=0.
- RUN:
  - Any req bit set: winner = first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Same edge: ack[winner]<=1, value<=lfsr (pre-step), lfsr<=step(lfsr), ptr<=(winner+1) mod N_REQ, state=GRANT.
  - No req: nothing changes.
  - Latency: req sampled high at edge k -> ack high after edge k.
- GRANT:
  - ack and value held while req[winner]=1.
  - Edge with req[winner]=0: ack<=0, state=RUN. The next grant can occur no earlier than the following edge.
  - Other req bits have no effect in GRANT.
- seed_load:
  - Overrides everything, any state: lfsr<=(seed==0 ? DEFAULT_SEED : seed), counter=WARMUP, ack<=0, state=WARM (RUN if WARMUP=0).
  - value and ptr are unchanged.
  - A grant that would occur on the same edge is suppressed.
- Zero lock: an all-zero LFSR state is unreachable. Reset and seed paths substitute DEFAULT_SEED.
- Reset mid-GRANT: ack drops immediately (async) and the full reset state applies.
- ack is never multi-hot. At most one grant is outstanding at a time.

Test Plan:
- WARMUP=0, reset, then req=4'b0001 -> ack=4'b0001, value=16'hACE1; drop req, ack falls one edge later; req[0] again -> value=16'h59C3; third -> 16'hB387.
- WARMUP=0, req=4'b1111 re-raised after each ack drop -> grant order 0,1,2,3,0; ptr wraps; ack always one-hot.
- WARMUP=16 after reset with req=4'b0010 held -> busy=1 and ack=0 for 16 edges; ready rises; ack=4'b0010 on the next edge. value equals the LFSR state after 16 steps from 16'hACE1 (checked against a bench model).
- seed_load with seed=16'h0000, WARMUP=0 -> first grant value 16'hACE1; seed_load with seed=16'h1234 -> first grant value 16'h1234.
- seed_load asserted during GRANT, and again on the same edge as a new req -> ack cleared immediately; no grant on the collision edge; value unchanged; next grant returns the new seed.
- reset asserted mid-GRANT, asynchronously between edges -> ack=0, value=16'h0000, busy=1 (WARMUP=16) before the next clock edge.

Source files
------------

// File: rtl/lfsr_rng_arbiter.sv
// Shared 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) served to N_REQ requesters
// through round-robin arbitration and a four-phase req/ack handshake.
module lfsr_rng_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          WARMUP       = 16,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [15:0]      value,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  // Handshake: a requester raises req[i] and holds it until ack[i] is seen;
  // ack[i] (with value) stays high until req[i] drops, then falls one edge later.

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    RUN   = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam state_t     START    = (WARMUP == 0) ? RUN : WARM;
  localparam logic [7:0] WARM_CNT = 8'(WARMUP);

  state_t             state, state_d;
  logic [15:0]        lfsr, lfsr_d;
  logic [7:0]         cnt, cnt_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [PTR_W-1:0]   win;
  logic [N_REQ-1:0]   ack_d;
  logic [15:0]        value_d;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // First set request at or above p, wrapping around N_REQ.
  function automatic logic [PTR_W-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] w;
    logic             found;
    int               idx;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = PTR_W'(idx);
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    cnt_d   = cnt;
    ptr_d   = ptr;
    ack_d   = ack;
    value_d = value;
    win     = pick(req, ptr);

    if (seed_load) begin
      // A zero seed would lock the LFSR, so it is replaced by the default.
      lfsr_d  = (seed == 16'h0000) ? DEFAULT_SEED : seed;
      cnt_d   = WARM_CNT;
      ack_d   = '0;
      state_d = START;
    end else begin
      case (state)
        WARM: begin
          lfsr_d = lfsr_step(lfsr);
          ack_d  = '0;
          if (cnt <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt - 8'd1;
          end
        end
        RUN: begin
          if (|req) begin
            ack_d   = N_REQ'(1) << win;
            value_d = lfsr;
            lfsr_d  = lfsr_step(lfsr);
            ptr_d   = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            state_d = GRANT;
          end
        end
        GRANT: begin
          // Only the granted requester's line matters here.
          if (!(|(req & ack))) begin
            ack_d   = '0;
            state_d = RUN;
          end
        end
        default: begin
          ack_d   = '0;
          state_d = START;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= START;
      lfsr  <= DEFAULT_SEED;
      cnt   <= WARM_CNT;
      ptr   <= '0;
      ack   <= '0;
      value <= 16'h0000;
    end else begin
      state <= state_d;
      lfsr  <= lfsr_d;
      cnt   <= cnt_d;
      ptr   <= ptr_d;
      ack   <= ack_d;
      value <= value_d;
    end
  end

  assign ready     = (state == RUN);
  assign busy      = (state == WARM);
  assign fsm_state = state;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: one instance with WARMUP=0 (u0) and one with
// WARMUP=16 (u16); expected grants come from a bench-side LFSR/round-robin model.
module tb_lfsr_rng_arbiter;

  logic        clock;
  logic        reset;

  logic        seed_load0, seed_load1;
  logic [15:0] seed0, seed1;
  logic [3:0]  req0, req1;
  logic [3:0]  ack0, ack1;
  logic [15:0] value0, value1;
  logic        ready0, ready1, busy0, busy1;
  logic [1:0]  st0, st1;

  lfsr_rng_arbiter #(.N_REQ(4), .WARMUP(0), .DEFAULT_SEED(16'hACE1)) u0 (
    .clock(clock), .reset(reset), .seed_load(seed_load0), .seed(seed0),
    .req(req0), .ack(ack0), .value(value0), .ready(ready0), .busy(busy0),
    .fsm_state(st0)
  );

  lfsr_rng_arbiter #(.N_REQ(4), .WARMUP(16), .DEFAULT_SEED(16'hACE1)) u16 (
    .clock(clock), .reset(reset), .seed_load(seed_load1), .seed(seed1),
    .req(req1), .ack(ack1), .value(value1), .ready(ready1), .busy(busy1),
    .fsm_state(st1)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard entries: {expected ack, expected value}
  logic [19:0] exp_q[$];

  logic [15:0] m_lfsr0;
  int          m_ptr0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic int model_pick(input logic [3:0] r, input int p);
    int k;
    k = p;
    repeat (4) begin
      if (r[k]) return k;
      k = (k + 1) % 4;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_lfsr0 = 16'hACE1;
    m_ptr0  = 0;
  endtask

  task automatic wait_ack0(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ack0 == 4'b0000 && lat < 8);
  endtask

  task automatic grant0(input logic [3:0] r, output logic [3:0] got_ack,
                        output logic [15:0] got_val);
    int          w;
    int          lat;
    logic [19:0] e;
    w = model_pick(r, m_ptr0);
    exp_q.push_back({4'(1 << w), m_lfsr0});
    m_lfsr0 = model_step(m_lfsr0);
    m_ptr0  = (w + 1) % 4;
    req0 = r;
    wait_ack0(lat);
    check("grant_latency", lat, 1);
    e = exp_q.pop_front();
    check("ack_onehot", {31'd0, $onehot(ack0)}, 1);
    check("grant_ack", ack0, e[19:16]);
    check("grant_value", value0, e[15:0]);
    got_ack = ack0;
    got_val = value0;
    tick();
    check("ack_held", ack0, e[19:16]);
    check("value_held", value0, e[15:0]);
    req0 = 4'b0000;
    tick();
    check("ack_drop", ack0, 0);
    check("ready_after_drop", ready0, 1);
  endtask

  task automatic load_seed0(input logic [15:0] s);
    seed0      = s;
    seed_load0 = 1'b1;
    tick();
    seed_load0 = 1'b0;
    m_lfsr0 = (s == 16'h0000) ? 16'hACE1 : s;
    check("seed_ack_clear", ack0, 0);
    check("seed_ready", ready0, 1);
  endtask

  logic [3:0]  a;
  logic [15:0] v;
  logic [15:0] old_v;
  logic [15:0] m16;
  logic [3:0]  exp_order[5];
  int          lat;
  logic [19:0] e;

  initial begin
    reset = 1'b1;
    seed_load0 = 1'b0; seed_load1 = 1'b0;
    seed0 = 16'h0; seed1 = 16'h0;
    req0 = 4'b0; req1 = 4'b0;
    m_lfsr0 = 16'hACE1;
    m_ptr0  = 0;
    #12;
    check("rst_ack0", ack0, 0);
    check("rst_value0", value0, 16'h0000);
    check("rst_busy16", busy1, 1);
    do_reset();
    check("rst_ready0", ready0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_ready16", ready1, 0);

    // basic grants on requester 0
    grant0(4'b0001, a, v);
    check("seq_v1", v, 16'hACE1);
    grant0(4'b0001, a, v);
    check("seq_v2", v, 16'h59C3);
    grant0(4'b0001, a, v);
    check("seq_v3", v, 16'hB387);

    // zero seed falls back to the default, non-zero seed is used as-is
    load_seed0(16'h0000);
    grant0(4'b0001, a, v);
    check("seed0_value", v, 16'hACE1);
    load_seed0(16'h1234);
    grant0(4'b0001, a, v);
    check("seed1234_value", v, 16'h1234);

    // seed_load during GRANT
    exp_q.push_back({4'(1 << model_pick(4'b0001, m_ptr0)), m_lfsr0});
    m_ptr0  = (model_pick(4'b0001, m_ptr0) + 1) % 4;
    m_lfsr0 = model_step(m_lfsr0);
    req0 = 4'b0001;
    wait_ack0(lat);
    check("g5_latency", lat, 1);
    e = exp_q.pop_front();
    check("g5_ack", ack0, e[19:16]);
    check("g5_value", value0, e[15:0]);
    old_v = value0;
    seed0 = 16'hC0DE;
    seed_load0 = 1'b1;
    tick();
    seed_load0 = 1'b0;
    req0 = 4'b0000;
    m_lfsr0 = 16'hC0DE;
    check("sl_grant_ack", ack0, 0);
    check("sl_grant_value", value0, old_v);
    check("sl_grant_ready", ready0, 1);
    tick();
    check("sl_idle_ack", ack0, 0);
    grant0(4'b0010, a, v);
    check("sl_new_seed", v, 16'hC0DE);
    check("sl_new_ack", a, 4'b0010);

    // seed_load on the same edge as a new request
    old_v = value0;
    seed1 = 16'h0;
    seed0 = 16'hBEEF;
    seed_load0 = 1'b1;
    req0 = 4'b0100;
    m_lfsr0 = 16'hBEEF;
    tick();
    seed_load0 = 1'b0;
    check("coll_ack", ack0, 0);
    check("coll_value", value0, old_v);
    exp_q.push_back({4'(1 << model_pick(4'b0100, m_ptr0)), m_lfsr0});
    m_ptr0  = (model_pick(4'b0100, m_ptr0) + 1) % 4;
    m_lfsr0 = model_step(m_lfsr0);
    wait_ack0(lat);
    check("coll_latency", lat, 1);
    e = exp_q.pop_front();
    check("coll_next_ack", ack0, e[19:16]);
    check("coll_next_value", value0, e[15:0]);
    check("coll_next_const", value0, 16'hBEEF);
    req0 = 4'b0000;
    tick();
    check("coll_drop", ack0, 0);

    // round robin with all requests raised
    do_reset();
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      grant0(4'b1111, a, v);
      check($sformatf("rr_order%0d", i), a, exp_order[i]);
    end

    // warm-up with a request held from reset
    req1 = 4'b0010;
    do_reset();
    check("warm_busy0", busy1, 1);
    check("warm_ack0", ack1, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("warm_busy%0d", i), busy1, 1);
      check($sformatf("warm_ack%0d", i), ack1, 0);
    end
    tick();
    check("warm_ready", ready1, 1);
    check("warm_done_ack", ack1, 0);
    m16 = 16'hACE1;
    for (int i = 0; i < 16; i++) m16 = model_step(m16);
    exp_q.push_back({4'b0010, m16});
    tick();
    e = exp_q.pop_front();
    check("warm_grant_ack", ack1, e[19:16]);
    check("warm_grant_value", value1, e[15:0]);

    // asynchronous reset in the middle of a grant
    tick();
    check("warm_ack_held", ack1, 4'b0010);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_ack", ack1, 0);
    check("async_rst_value", value1, 16'h0000);
    check("async_rst_busy", busy1, 1);
    #1;
    reset = 1'b0;
    req1 = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
